connect_merge: RTL

//  N-to-1 merge stage for packet streams: round-robin arbitration over CONNECT_NUM valid/ready inputs

---
 rtl/connect_merge_pkg.sv | 12 +
 rtl/connect_merge_arb.sv | 49 ++++
 rtl/connect_merge.sv | 98 +++++++++
 3 files changed

// File: rtl/connect_merge_pkg.sv
// Shared constants and helpers for the connect_merge N-to-1 packet merge stage.
// Optional feature macro: CONNECT_MERGE_SRC_ID_EN (adds per-entry source index / SEND_SRC).
package connect_merge_pkg;

    localparam int PACKET_WIDTH = 192;
    localparam int BUF_DEPTH    = 2;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/connect_merge_arb.sv
// Round-robin arbiter for connect_merge: rr pointer register plus priority search from it.
// Optional feature macro of the parent (CONNECT_MERGE_SRC_ID_EN) does not affect this block.
module connect_merge_arb
    import connect_merge_pkg::*;
#(
    parameter  int CONNECT_NUM = 3,
    localparam int SEL_WIDTH   = $clog2(CONNECT_NUM)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CONNECT_NUM-1:0] req,
    input  logic                   advance,
    output logic [CONNECT_NUM-1:0] grant,
    output logic [SEL_WIDTH-1:0]   grant_idx,
    output logic                   grant_vld
);

    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH:0]   cand_sum;
    logic [SEL_WIDTH-1:0] cand;

    // Search starts at rr_ptr and wraps; rr_ptr < CONNECT_NUM so one subtraction suffices.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < CONNECT_NUM; k++) begin
            cand_sum = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(k);
            if (cand_sum >= (SEL_WIDTH+1)'(CONNECT_NUM))
                cand_sum = cand_sum - (SEL_WIDTH+1)'(CONNECT_NUM);
            cand = cand_sum[SEL_WIDTH-1:0];
            if (!grant_vld && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_vld   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= SEL_WIDTH'(wrap_inc(32'(grant_idx), CONNECT_NUM));
    end

endmodule

// File: rtl/connect_merge.sv
// N-to-1 round-robin packet merge into a 2-entry output FIFO sustaining one packet per cycle.
// Define CONNECT_MERGE_SRC_ID_EN to store the granted index per entry and expose SEND_SRC.
module connect_merge
    import connect_merge_pkg::*;
#(
    parameter  int DATA_WIDTH  = PACKET_WIDTH,
    parameter  int CONNECT_NUM = 3,
    localparam int SEL_WIDTH   = $clog2(CONNECT_NUM)
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
    output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
    input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
    output logic                              SEND_VALID,
    input  logic                              SEND_READY,
    output logic [DATA_WIDTH-1:0]             SEND_DATA
`ifdef CONNECT_MERGE_SRC_ID_EN
    ,
    output logic [SEL_WIDTH-1:0]              SEND_SRC
`endif
);

    logic [CONNECT_NUM-1:0] grant;
    logic [SEL_WIDTH-1:0]   grant_idx;
    logic                   grant_vld;
    logic                   has_room;
    logic                   push;
    logic                   pop;
    logic [DATA_WIDTH-1:0]  sel_data;

    logic [1:0]             count_p1;
    logic                   wr_ptr_p1;
    logic                   rd_ptr_p1;
    logic [DATA_WIDTH-1:0]  buf_data_p1 [BUF_DEPTH];

    connect_merge_arb #(
        .CONNECT_NUM (CONNECT_NUM)
    ) u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .req       (RECEIVE_VALID),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Ready is gated by RST so nothing is offered while reset is held.
    assign has_room      = count_p1 < 2'(BUF_DEPTH);
    assign RECEIVE_READY = (RST && has_room) ? grant : '0;
    assign push          = RST && has_room && grant_vld;
    assign pop           = SEND_VALID && SEND_READY;
    assign sel_data      = RECEIVE_DATA[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Stage p1: buffer control and storage
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_p1  <= '0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_p1 <= count_p1 + 2'd1;
                2'b01:   count_p1 <= count_p1 - 2'd1;
                default: count_p1 <= count_p1;
            endcase
            if (push)
                wr_ptr_p1 <= ~wr_ptr_p1;
            if (pop)
                rd_ptr_p1 <= ~rd_ptr_p1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            buf_data_p1[wr_ptr_p1] <= sel_data;
    end

`ifdef CONNECT_MERGE_SRC_ID_EN
    logic [SEL_WIDTH-1:0] buf_src_p1 [BUF_DEPTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < BUF_DEPTH; i++)
                buf_src_p1[i] <= '0;
        end else if (push) begin
            buf_src_p1[wr_ptr_p1] <= grant_idx;
        end
    end

    assign SEND_SRC = buf_src_p1[rd_ptr_p1];
`endif

    assign SEND_VALID = (count_p1 != 2'd0);
    assign SEND_DATA  = buf_data_p1[rd_ptr_p1];

endmodule
